vedic_pp_combine_seq: RTL and testbench
=======================================

Name: vedic_pp_combine_seq

Overview:
Sequential combiner for the 32-bit vector Vedic multiplier. It accepts the four half-width Urdhva-Tiryakbhyam partial products of one lane: AL*BL, AH*BL, AL*BH and AH*BH. It reduces them to the full 2*WIDTH product over three cycles, time-sharing one internal WIDTH+1-bit wrap-around adder stage. The block sits downstream of the quadrant multipliers and upstream of the lane result register, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand width of the full multiply; each partial product is WIDTH bits; must be even and >= 4
HALF, WIDTH/2, shift of the middle partial products (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  partial-product set valid
in_ready  output  1  block can accept a set
pp_ll  input  WIDTH  AL*BL
pp_hl  input  WIDTH  AH*BL
pp_lh  input  WIDTH  AL*BH
pp_hh  input  WIDTH  AH*BH
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  combined result
busy  output  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- On reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. All internal registers (pp copies, mid, carry) are cleared.
- Reset asserted mid-operation aborts the transaction with no output. After release, the block is in IDLE and accepts on the next edge.
- States: IDLE, MID, LO, HI, OUT.
- IDLE: in_ready=1. If in_valid=1 at the edge, capture all four pp inputs and go to MID. Inputs are not sampled again after capture.
- MID: mid = pp_hl + pp_lh, WIDTH+1 bits, carry kept. Go to LO.
- LO: low = pp_ll + {mid[HALF-1:0], HALF zeros}, WIDTH+1 bits. Store product[WIDTH-1:0] = low[WIDTH-1:0] and c = low[WIDTH]. Go to HI.
- HI: product[2W-1:W] = (pp_hh + zero-extended mid[WIDTH:HALF] + c) mod 2^WIDTH. Go to OUT.
- OUT: out_valid=1. product is held stable while out_ready=0. When out_ready=1 at the edge, go to IDLE with out_valid=0.
- Handshake:
  - in_ready=1 only in IDLE; no input is accepted in OUT even if out_ready=1.
  - in_valid while busy is ignored; the upstream stage must hold it.
- Latency: acceptance edge E0; out_valid rises after edge E3, i.e. 3 clocks after acceptance.
- Throughput: one product per 5 cycles with out_ready tied high.
- Arithmetic:
  - Unsigned throughout.
  - Result equals (pp_ll + (pp_hl<<HALF) + (pp_lh<<HALF) + (pp_hh<<WIDTH)) mod 2^(2*WIDTH).
  - For genuine partial products no truncation occurs. For arbitrary inputs the top carry is discarded.
- product updates only in LO (lower half) and HI (upper half). It is otherwise held, including in IDLE after handoff.
- busy = (state != IDLE).
- in_ready and out_valid are registered-state decodes only; there is no combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset then a single set, WIDTH=32, A=3, B=5 (pp_ll=15, others 0) -> out_valid 3 clocks after acceptance, product=0x000000000000000F, in_ready=0 during MID..OUT.
- All-ones operands (all four pp=0xFFFE0001) -> product=0xFFFFFFFE00000001.
- Carry from low half: pp_ll=0xFFFFFFFF, pp_hl=1, pp_lh=0, pp_hh=0 -> product=0x000000010000FFFF (c=1 propagated). Also A=B=0x00010000 (pp_hh=1) -> product=0x0000000100000000.
- Backpressure: out_ready=0 for 6 cycles with a new in_valid pending -> out_valid and product stable, in_ready=0, pending set not accepted. Release out_ready -> handoff, IDLE, pending set accepted on the next edge.
- Reset mid-op: assert rst_n=0 during LO -> out_valid=0, product=0, busy=0 immediately (asynchronously). After release, a new set (A=7, B=9) -> product=63, no stale output.
- Back-to-back, out_ready tied high, 100 random genuine operand pairs -> every product matches the reference model, one result per 5 cycles.

Source files
------------

// File: rtl/vedic_pp_combine_seq_if.sv
// Handshake and data bundle between the quadrant multipliers, the combiner and the lane result register.
interface vedic_pp_combine_seq_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   pp_ll;
  logic [WIDTH-1:0]   pp_hl;
  logic [WIDTH-1:0]   pp_lh;
  logic [WIDTH-1:0]   pp_hh;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, pp_ll, pp_hl, pp_lh, pp_hh, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, pp_ll, pp_hl, pp_lh, pp_hh, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/vedic_pp_combine_seq.sv
// Folds four half-width partial products into a 2*WIDTH product using one shared WIDTH+1-bit adder.
// Latency 3 clocks from acceptance to out_valid; holds the result and refuses input until out_ready.
module vedic_pp_combine_seq #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  vedic_pp_combine_seq_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [2:0] {IDLE, MID, LO, HI, OUT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   ll_q;
  logic [WIDTH-1:0]   hl_q;
  logic [WIDTH-1:0]   lh_q;
  logic [WIDTH-1:0]   hh_q;
  logic [WIDTH:0]     mid_q;
  logic               carry_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH:0]     add_sum;

  // Operand steering for the single shared adder; each step uses it exactly once.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = MID;
      MID: begin
        add_a     = hl_q;
        add_b     = lh_q;
        state_nxt = LO;
      end
      LO: begin
        add_a     = ll_q;
        add_b     = {mid_q[HALF-1:0], {HALF{1'b0}}};
        state_nxt = HI;
      end
      HI: begin
        add_a     = hh_q;
        add_b     = {{(HALF-1){1'b0}}, mid_q[WIDTH:HALF]};
        add_cin   = carry_q;
        state_nxt = OUT;
      end
      OUT: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ll_q      <= '0;
      hl_q      <= '0;
      lh_q      <= '0;
      hh_q      <= '0;
      mid_q     <= '0;
      carry_q   <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ll_q <= bus.pp_ll;
          hl_q <= bus.pp_hl;
          lh_q <= bus.pp_lh;
          hh_q <= bus.pp_hh;
        end
        MID: mid_q <= add_sum;
        LO: begin
          product_q[WIDTH-1:0] <= add_sum[WIDTH-1:0];
          carry_q              <= add_sum[WIDTH];
        end
        // Top carry of the high-half sum is dropped: the result is modulo 2^(2*WIDTH).
        HI: product_q[2*WIDTH-1:WIDTH] <= add_sum[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_q;
endmodule

// File: tb/tb_vedic_pp_combine_seq.sv
// Directed table vectors, backpressure and reset corner cases, then back-to-back random operand pairs.
module tb_vedic_pp_combine_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  vedic_pp_combine_seq_if #(.WIDTH(32)) bus ();

  vedic_pp_combine_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ll;
    logic [31:0] hl;
    logic [31:0] lh;
    logic [31:0] hh;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Presents a set and returns #1 after the accepting edge (DUT now in MID).
  task automatic send(input logic [31:0] ll, input logic [31:0] hl,
                      input logic [31:0] lh, input logic [31:0] hh);
    int n;
    n = 0;
    bus.pp_ll = ll;
    bus.pp_hl = hl;
    bus.pp_lh = lh;
    bus.pp_hh = hh;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) timeout("send_in_ready");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Called right after acceptance with out_ready=1; checks exact 3-clock latency and handoff.
  task automatic receive(input logic [63:0] exp, input string name);
    chk({name, "_busy_mid"}, 64'(bus.busy), 64'd1);
    chk({name, "_rdy_mid"}, 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk({name, "_vld_lo"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_rdy_lo"}, 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk({name, "_vld_hi"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_vld_out"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_rdy_out"}, 64'(bus.in_ready), 64'd0);
    chk({name, "_product"}, bus.product, exp);
    @(posedge clk); #1;
    chk({name, "_vld_after"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_idle_after"}, 64'(bus.in_ready), 64'd1);
    chk({name, "_held_after"}, bus.product, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd15, 32'd0, 32'd0, 32'd0, 64'h0000_0000_0000_000F, "a3_b5"};
    vecs[1] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001,
                64'hFFFF_FFFE_0000_0001, "all_ones"};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 64'h0000_0001_0000_FFFF, "low_carry"};
    vecs[3] = '{32'd0, 32'd0, 32'd0, 32'd1, 64'h0000_0001_0000_0000, "hh_only"};
    vecs[4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 64'h0001_FFFF_FFFE_0000, "mid_carry"};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'h0001_FFFF_FFFD_FFFF, "truncate"};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.pp_ll = '0;
    bus.pp_hl = '0;
    bus.pp_lh = '0;
    bus.pp_hh = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].ll, vecs[i].hl, vecs[i].lh, vecs[i].hh);
      receive(vecs[i].exp, vecs[i].name);
    end

    // Backpressure with a second set waiting upstream.
    bus.out_ready = 1'b0;
    send(32'h0000_1234, 32'h10, 32'h20, 32'h5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("bp_vld", 64'(bus.out_valid), 64'd1);
    bus.pp_ll = 32'd100;
    bus.pp_hl = '0;
    bus.pp_lh = '0;
    bus.pp_hh = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_vld", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_product", bus.product, 64'h0000_0005_0030_1234);
      chk("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_vld", 64'(bus.out_valid), 64'd0);
    chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
    chk("bp_release_held", bus.product, 64'h0000_0005_0030_1234);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    receive(64'd100, "bp_pending");

    // Asynchronous reset while the block is in LO.
    send(32'h55, 32'h1, 32'h1, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_product", bus.product, 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_vld", 64'(bus.out_valid), 64'd0);
    send(32'd63, 32'd0, 32'd0, 32'd0);
    receive(64'd63, "a7_b9");

    // Back-to-back random genuine partial products, out_ready tied high.
    fork
      begin : drv
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] al;
        logic [31:0] ah;
        logic [31:0] bl;
        logic [31:0] bh;
        for (int i = 0; i < 100; i++) begin
          a  = $urandom;
          b  = $urandom;
          al = {16'd0, a[15:0]};
          ah = {16'd0, a[31:16]};
          bl = {16'd0, b[15:0]};
          bh = {16'd0, b[31:16]};
          exp_q.push_back(64'(a) * 64'(b));
          send(al * bl, ah * bl, al * bh, ah * bh);
        end
      end
      begin : mon
        int n;
        int last;
        last = 0;
        for (int k = 0; k < 100; k++) begin
          n = 0;
          @(posedge clk); #1;
          while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
          end
          if (n >= 50) begin
            timeout("b2b_out_valid");
          end else if (exp_q.size() == 0) begin
            timeout("b2b_unexpected_output");
          end else begin
            chk("b2b_product", bus.product, exp_q.pop_front());
            if (k > 0) chk("b2b_interval", 64'(cyc - last), 64'd5);
            last = cyc;
          end
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
